interval_timer: RTL and testbench
=================================

Name: interval_timer

Overview:
Memory-mapped countdown timer peripheral on the core data bus. It is the interrupt source feeding one bit of the cp0 `devices_interrupt` vector.
- Software loads a count and optional reload value.
- The block decrements the count at a prescaled rate.
- On expiry it raises a sticky, level-high interrupt request.

Parameters:
- BASE_ADDR, 32'hFFFF0000, 32-byte-aligned base of the register window; decode uses addr[31:5].
- PRESCALE, 1, clock cycles per count tick; legal range 1..65535; 0 is illegal.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr_i  in  32  data bus address from core
- data_i  in  32  write data from core
- data_sel_i  in  4  byte-lane enables; bit n covers data[8n+7:8n]
- we_i  in  1  write strobe
- rd_i  in  1  read strobe
- data_o  out  32  read data
- valid_o  out  1  access acknowledge
- irq_o  out  1  interrupt request to cp0 `devices_interrupt[n]`

Behaviour:
- Register map, offset = addr[4:2]:
  - 0 COUNT: r/w.
  - 1 RELOAD: r/w.
  - 2 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); other bits read 0.
  - 3 STATUS: bit0 PEND; write 1 to bit0 clears it (W1C), writing 0 has no effect.
  - 4..7: read 0, writes ignored (except with the optional feature).
- Hit = (addr_i[31:5] == BASE_ADDR[31:5]) & (we_i | rd_i).
- Bus timing:
  - Zero wait state: valid_o = hit, combinational.
  - data_o is combinational from registers when hit & rd_i, else 0.
  - Writes commit on the rising clk edge of the hit cycle.
  - Writes honour data_sel_i per byte; unselected bytes are unchanged.
- Reset: COUNT, RELOAD, CTRL, PEND, and the prescaler counter are all 0. irq_o = 0, valid_o = 0, data_o = 0.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN = 1.
  - Produces a one-cycle tick when it wraps.
  - Held at 0 while EN = 0.
  - With PRESCALE = 1, tick = EN on every cycle.
- On tick, COUNT update:
  - COUNT > 1: COUNT <= COUNT-1.
  - COUNT == 1: set PEND; COUNT <= AUTO ? RELOAD : 0.
  - COUNT == 0: no change and no PEND (timer idle). This applies even with AUTO = 1; software must write COUNT to restart.
- irq_o = PEND & IE, from flops with no extra register stage. PEND latches regardless of IE; setting IE later while PEND = 1 asserts irq_o immediately.
- Simultaneous events:
  - COUNT write in a tick cycle: the write wins, and the prescaler counter is cleared to 0 in that cycle.
  - Expiry and PEND W1C in the same cycle: the set wins, so PEND stays 1.
  - RELOAD write in the expiry cycle with AUTO: COUNT takes the old RELOAD; the new value applies from the next reload.
  - EN cleared mid-prescale: the prescaler resets and the partial period is lost.
- Reset mid-count: all state returns to reset values on the next edge; irq_o drops in the cycle after rst is sampled high.
- Arithmetic is 32-bit unsigned with no wrap below 0.

Optional Feature:
- Macro: INTERVAL_TIMER_CYCLE_EN.
- Defined:
  - Adds a free-running 64-bit cycle counter, reset 0, incrementing every clk regardless of EN.
  - Offset 4 reads the low 32 bits. That same read latches the high 32 bits into a shadow register.
  - Offset 5 reads the shadow, giving a coherent 64-bit pair.
  - Writes to offsets 4 and 5 are ignored.
- Undefined: the counter and shadow are absent, offsets 4 and 5 read 0, and no extra flops are added.

Test Plan:
- Reset: with rst high for 2 cycles, all reads return 0 and irq_o = 0. Then write COUNT = 100 and CTRL = 5 (EN, IE). irq_o must rise exactly 100 cycles after the write edge, and COUNT must read 0 afterwards and stay 0.
- Auto-reload: with PRESCALE = 4, RELOAD = 3, COUNT = 3, CTRL = 7, PEND sets every 12 cycles. With STATUS written 1 after each rise, irq_o pulses periodically.
- W1C race: time a STATUS = 1 write to the expiry cycle; PEND must remain 1. A second write of 1 clears it, and irq_o falls on the next cycle.
- IE masking: with CTRL = 1, PEND reads 1 after expiry while irq_o = 0. Writing CTRL = 5 raises irq_o in the next cycle.
- Byte lanes and decode: a write of 32'hAABBCCDD to RELOAD with sel = 4'b0101 reads back 32'h00BB00DD. An access to BASE_ADDR+32 gives valid_o = 0 and no state change.
- Mid-count reset (and, with INTERVAL_TIMER_CYCLE_EN, cycle readout):
  - With COUNT = 50 counting, assert rst at count 20: COUNT, CTRL and irq_o are 0 afterwards.
  - With the feature defined, read offsets 4 then 5 after 1000 cycles and check the values are consistent.

Source files
------------

// File: rtl/interval_timer_if.sv
// interval_timer data bus: core-side address/data/strobes and
// the peripheral's combinational acknowledge and read data.
interface interval_timer_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  data_sel_i;
  logic        we_i;
  logic        rd_i;
  logic [31:0] data_o;
  logic        valid_o;

  modport master (
    output addr_i, data_i, data_sel_i, we_i, rd_i,
    input  data_o, valid_o
  );

  modport slave (
    input  addr_i, data_i, data_sel_i, we_i, rd_i,
    output data_o, valid_o
  );
endinterface

// File: rtl/interval_timer.sv
// Memory-mapped countdown timer with sticky level irq.
// INTERVAL_TIMER_CYCLE_EN adds a 64-bit cycle counter at offsets 4/5.
module interval_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic           clk,
  input  logic           rst,
  interval_timer_if.slave bus,
  output logic           irq_o
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [31:0] count;
  logic [31:0] reload;
  logic [2:0]  ctrl;
  logic        pend;
  logic [15:0] pcnt;

  logic        hit;
  logic [2:0]  off;
  logic        wr;
  logic        wr_cnt;
  logic        wr_rld;
  logic        wr_ctl;
  logic        wr_sts;
  logic        en;
  logic        tick;
  logic        expire;
  logic [31:0] rdata;

  logic unused;
  assign unused = ^{bus.addr_i[1:0]};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = sel[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  assign hit = (bus.addr_i[31:5] == BASE_ADDR[31:5])
             & (bus.we_i | bus.rd_i);
  assign off    = bus.addr_i[4:2];
  assign wr     = hit & bus.we_i;
  assign wr_cnt = wr & (off == 3'd0);
  assign wr_rld = wr & (off == 3'd1);
  assign wr_ctl = wr & (off == 3'd2);
  assign wr_sts = wr & (off == 3'd3);

  assign en     = ctrl[0];
  assign tick   = en & (pcnt == PS_LAST);
  // A COUNT write in a tick cycle overrides the whole tick, expiry included.
  assign expire = tick & ~wr_cnt & (count == 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      ctrl   <= '0;
      pend   <= 1'b0;
      pcnt   <= '0;
    end else begin
      if (!en || wr_cnt || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 16'd1;

      if (wr_cnt)
        count <= merge(count, bus.data_i, bus.data_sel_i);
      else if (expire)
        count <= ctrl[1] ? reload : 32'd0;
      else if (tick && count > 32'd1)
        count <= count - 32'd1;

      if (wr_rld)
        reload <= merge(reload, bus.data_i, bus.data_sel_i);

      if (wr_ctl && bus.data_sel_i[0])
        ctrl <= bus.data_i[2:0];

      if (expire)
        pend <= 1'b1;
      else if (wr_sts && bus.data_sel_i[0] && bus.data_i[0])
        pend <= 1'b0;
    end
  end

`ifdef INTERVAL_TIMER_CYCLE_EN
  logic [63:0] cyc;
  logic [31:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc    <= '0;
      shadow <= '0;
    end else begin
      cyc <= cyc + 64'd1;
      // Reading the low half freezes the matching high half.
      if (hit && bus.rd_i && off == 3'd4)
        shadow <= cyc[63:32];
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (hit && bus.rd_i) begin
      case (off)
        3'd0:    rdata = count;
        3'd1:    rdata = reload;
        3'd2:    rdata = {29'd0, ctrl};
        3'd3:    rdata = {31'd0, pend};
`ifdef INTERVAL_TIMER_CYCLE_EN
        3'd4:    rdata = cyc[31:0];
        3'd5:    rdata = shadow;
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign bus.data_o  = rdata;
  assign bus.valid_o = hit;
  assign irq_o       = pend & ctrl[2];

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: register vectors,
// expiry timing, auto-reload, W1C race, IE masking and reset.
module tb_interval_timer;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        rd_s = 1'b0;
  logic        irq1;
  logic        irq4;
  int unsigned cyc = 0;

  int pass = 0;
  int total = 0;
  logic [31:0] expq[$];

  interval_timer_if b1 ();
  interval_timer_if b4 ();

  assign b1.addr_i     = addr;
  assign b1.data_i     = wdata;
  assign b1.data_sel_i = sel;
  assign b1.we_i       = we;
  assign b1.rd_i       = rd_s;
  assign b4.addr_i     = addr;
  assign b4.data_i     = wdata;
  assign b4.data_sel_i = sel;
  assign b4.we_i       = we;
  assign b4.rd_i       = rd_s;

  interval_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(b1), .irq_o(irq1)
  );

  interval_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4), .irq_o(irq4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      pass++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d,
                    input logic [3:0] s);
    @(negedge clk);
    addr  = BASE + {27'd0, off, 2'b00};
    wdata = d;
    sel   = s;
    we    = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rd(input int dev, input logic [2:0] off,
                    input logic [31:0] exp, input string nm);
    logic [31:0] act;
    @(negedge clk);
    addr = BASE + {27'd0, off, 2'b00};
    rd_s = 1'b1;
    expq.push_back(exp);
    #1;
    act = (dev != 0) ? b4.data_o : b1.data_o;
    check(nm, act, expq.pop_front());
    @(posedge clk);
    #1 rd_s = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  off;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tv[7];

  initial begin
    int n;
    bit found;
    int unsigned c0;

    tv[0] = '{3'd0, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF, "count_full"};
    tv[1] = '{3'd0, 32'h12345678, 4'b1000, 32'h12FFFFFF, "count_lane3"};
    tv[2] = '{3'd1, 32'hAABBCCDD, 4'b0101, 32'h00BB00DD, "reload_lanes"};
    tv[3] = '{3'd2, 32'hFFFFFFFE, 4'b1111, 32'h00000006, "ctrl_bits"};
    tv[4] = '{3'd3, 32'hFFFFFFFF, 4'b1111, 32'h00000000, "status_w1c"};
    tv[5] = '{3'd6, 32'hFFFFFFFF, 4'b1111, 32'h00000000, "off6_zero"};
    tv[6] = '{3'd7, 32'hFFFFFFFF, 4'b1111, 32'h00000000, "off7_zero"};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_irq", {31'd0, irq1}, 32'd0);
    check("rst_valid", {31'd0, b1.valid_o}, 32'd0);
    check("rst_data", b1.data_o, 32'd0);
    for (int i = 0; i < 4; i++)
      rd(0, 3'(i), 32'd0, "rst_read");

    for (int i = 0; i < 7; i++) begin
      wr(tv[i].off, tv[i].d, tv[i].s);
      rd(0, tv[i].off, tv[i].exp, tv[i].nm);
    end

    @(negedge clk);
    addr  = BASE + 32'd32;
    wdata = 32'h00001234;
    sel   = 4'hF;
    we    = 1'b1;
    #1 check("miss_valid", {31'd0, b1.valid_o}, 32'd0);
    @(posedge clk);
    #1 we = 1'b0;
    @(negedge clk);
    addr = BASE;
    rd_s = 1'b1;
    #1 check("hit_valid", {31'd0, b1.valid_o}, 32'd1);
    @(posedge clk);
    #1 rd_s = 1'b0;
    rd(0, 3'd0, 32'h12FFFFFF, "miss_nochange");

    do_reset();
    wr(3'd0, 32'd100, 4'hF);
    wr(3'd2, 32'd5, 4'hF);
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (irq1) begin
        n = i;
        found = 1'b1;
      end
    end
    check("irq_delay", n, 32'd100);
    rd(0, 3'd0, 32'd0, "count_idle");
    repeat (10) @(posedge clk);
    rd(0, 3'd0, 32'd0, "count_stays0");
    check("irq_sticky", {31'd0, irq1}, 32'd1);

    do_reset();
    wr(3'd1, 32'd3, 4'hF);
    wr(3'd0, 32'd3, 4'hF);
    wr(3'd2, 32'd7, 4'hF);
    c0 = cyc;
    for (int k = 1; k <= 3; k++) begin
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(posedge clk);
        #1;
        if (irq4) found = 1'b1;
      end
      check("auto_period", cyc - c0, 32'(12 * k));
      wr(3'd3, 32'd1, 4'hF);
      check("auto_clr", {31'd0, irq4}, 32'd0);
    end

    do_reset();
    wr(3'd0, 32'd3, 4'hF);
    wr(3'd2, 32'd5, 4'hF);
    repeat (2) @(posedge clk);
    wr(3'd3, 32'd1, 4'hF);
    check("race_irq", {31'd0, irq1}, 32'd1);
    rd(0, 3'd3, 32'd1, "race_pend");
    wr(3'd3, 32'd1, 4'hF);
    check("clr_irq", {31'd0, irq1}, 32'd0);
    rd(0, 3'd3, 32'd0, "clr_pend");
    wr(3'd3, 32'd0, 4'hF);

    do_reset();
    wr(3'd0, 32'd2, 4'hF);
    wr(3'd2, 32'd1, 4'hF);
    repeat (5) @(posedge clk);
    rd(0, 3'd3, 32'd1, "mask_pend");
    check("mask_irq", {31'd0, irq1}, 32'd0);
    wr(3'd2, 32'd5, 4'hF);
    check("unmask_irq", {31'd0, irq1}, 32'd1);

    do_reset();
    wr(3'd0, 32'd50, 4'hF);
    wr(3'd2, 32'd5, 4'hF);
    repeat (30) @(posedge clk);
    rd(0, 3'd0, 32'd20, "mid_count");
    do_reset();
    rd(0, 3'd0, 32'd0, "mid_rst_count");
    rd(0, 3'd2, 32'd0, "mid_rst_ctrl");
    check("mid_rst_irq", {31'd0, irq1}, 32'd0);

`ifdef INTERVAL_TIMER_CYCLE_EN
    repeat (1000) @(posedge clk);
    @(negedge clk);
    addr = BASE + 32'd16;
    rd_s = 1'b1;
    #1;
    total++;
    if (b1.data_o >= 32'd1000 && b1.data_o < 32'd1100)
      pass++;
    else
      $display("FAIL cyc_lo: got %0d want 1000..1099", b1.data_o);
    @(posedge clk);
    #1 rd_s = 1'b0;
    rd(0, 3'd5, 32'd0, "cyc_hi");
`else
    rd(0, 3'd4, 32'd0, "off4_zero");
    rd(0, 3'd5, 32'd0, "off5_zero");
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
